// File: rtl/shared_reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// shared_reg_arb_pkg
// Shared definitions for the shared-register write arbiter: the controller
// state encoding, default sizing constants and the owner-index width helper.
// -----------------------------------------------------------------------------
package shared_reg_arb_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  // Owner index width for a given requester count (never narrower than 1 bit).
  function automatic int calc_idxw(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner selection. Scans req starting at ptr, ascending and
// wrapping from N_REQ-1 to 0; the first set bit wins. With
// ARB_FIXED_PRIORITY_EN defined the scan always starts at index 0, so the
// lowest set request wins and ptr is ignored.
//
// Ports:
//   req_i   [N_REQ-1:0]  request vector
//   ptr_i   [IDXW-1:0]   round-robin start index
//   idx_o   [IDXW-1:0]   winning requester index (0 when nothing requested)
//   valid_o              at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             valid_o
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    int k;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      k = i;
`else
      k = (int'(ptr_i) + i) % N_REQ;
`endif
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
// Arbitrates write access to one shared WIDTH-bit register among N_REQ
// requesters and sequences a synchronous clear of it. Each operation takes
// two cycles: IDLE (sample clr/req) then GRANT or CLEAR. clr beats any req.
//
// Build option: define ARB_FIXED_PRIORITY_EN for fixed lowest-index priority
// (round-robin pointer removed); default is round-robin.
//
// Ports:
//   clock               sole clock, posedge
//   reset               asynchronous, active-high
//   clr                 request to clear q to 0
//   req   [N_REQ-1:0]   per-requester write request (level, held until gnt)
//   wdata [N_REQ*WIDTH] write lanes, lane i = wdata[i*WIDTH +: WIDTH]
//   gnt   [N_REQ-1:0]   one-hot grant, high only in GRANT
//   q     [WIDTH-1:0]   shared register contents
//   busy                state is not IDLE
//   owner [IDXW-1:0]    index of the last requester written
// -----------------------------------------------------------------------------
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = calc_idxw(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [IDXW-1:0]        owner
);

  arb_state_e       state_q, state_d;
  logic [IDXW-1:0]  winner_q, winner_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  ptr_cur;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_valid;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDXW-1:0]  ptr_q, ptr_d;
  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = '0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_cur),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    owner_d  = owner_q;
    data_d   = data_q;
`ifndef ARB_FIXED_PRIORITY_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
        end else if (pick_valid) begin
          // Winner is frozen here so GRANT never depends on live req.
          winner_d = pick_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        data_d  = wdata[int'(winner_q)*WIDTH +: WIDTH];
        owner_d = winner_q;
`ifndef ARB_FIXED_PRIORITY_EN
        ptr_d   = (winner_q == IDXW'(N_REQ - 1)) ? '0 : winner_q + IDXW'(1);
`endif
        state_d = IDLE;
      end
      CLEAR: begin
        data_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Outputs decode registered state only; no path from req or clr.
  always_comb begin
    gnt = '0;
    if (state_q == GRANT) gnt[winner_q] = 1'b1;
  end

  assign busy  = (state_q != IDLE);
  assign q     = data_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Directed scenarios followed by randomized operations, checked against a
// transaction-level model of the arbiter (pointer, register value, owner).
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [IW-1:0]  owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr   = 0;
  logic [W-1:0] m_q   = '0;
  int         m_owner = 0;

  int cycle = 0;
  int last_win = -1;
  int last_gnt_cycle = -1;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .IDXW(IW)) dut (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner from the arbitration rule: the set indices in ascending order;
  // round-robin takes the first one at or above the pointer, else wraps to
  // the smallest; fixed priority always takes the smallest.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    int idxs[$];
    for (int i = 0; i < N; i++) if (r[i]) idxs.push_back(i);
    if (idxs.size() == 0) return -1;
`ifndef ARB_FIXED_PRIORITY_EN
    foreach (idxs[k]) if (idxs[k] >= ptr) return idxs[k];
`endif
    return idxs[0];
  endfunction

  // Raise request bits not already held, loading their lanes from 'lanes'.
  task automatic raise(input logic [N-1:0] bits, input logic [N*W-1:0] lanes);
    for (int i = 0; i < N; i++) begin
      if (bits[i] && !req[i]) begin
        wdata[i*W +: W] = lanes[i*W +: W];
        req[i] = 1'b1;
      end
    end
  endtask

  // One operation, entered and left at a negedge with the DUT in IDLE.
  // late_bits are raised during the busy cycle (deferred requests).
  task automatic op(input logic c, input logic [N-1:0] new_bits,
                    input logic [N-1:0] late_bits, input logic [N*W-1:0] lanes,
                    input string tag);
    int w;
    logic [W-1:0] exp_q;
    raise(new_bits, lanes);
    clr = c;
    @(posedge clock);
    @(negedge clock);
    w = -1;
    if (c) begin
      check({tag, "_clr_busy"}, 32'(busy), 32'd1);
      check({tag, "_clr_gnt"}, 32'(gnt), 32'd0);
      exp_q = '0;
    end else if (req != '0) begin
      w = model_pick(req, m_ptr);
      check({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      exp_q = wdata[w*W +: W];
      last_win = w;
      last_gnt_cycle = cycle;
      req[w] = 1'b0;
    end else begin
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_q"}, 32'(q), 32'(m_q));
      return;
    end
    clr = 1'b0;
    if (w >= 0) late_bits[w] = 1'b0;
    raise(late_bits, lanes);
    @(posedge clock);
    @(negedge clock);
    m_q = exp_q;
    if (w >= 0) begin
      m_owner = w;
      m_ptr = (w + 1) % N;
    end
    check({tag, "_q"}, 32'(q), 32'(m_q));
    check({tag, "_owner"}, 32'(owner), 32'(m_owner));
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] lanes;
    int prev;

    // ---- reset state ----
    reset = 1'b1; clr = 1'b0; req = '0; wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    reset = 1'b0;

    // ---- reset asserted mid-GRANT ----
    wdata[0 +: W] = 8'hA5;
    req = 4'b0001;
    @(posedge clock);
    @(negedge clock);
    check("midrst_gnt_before", 32'(gnt), 32'b0001);
    reset = 1'b1;
    #1;
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_q_after", 32'(q), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);
    check("midrst_owner_after", 32'(owner), 32'd0);

`ifndef ARB_FIXED_PRIORITY_EN
    // ---- round-robin with all requests held ----
    lanes = {8'h13, 8'h12, 8'h11, 8'h10};
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 4'b1111, 4'b0000, lanes, "rr");
      check("rr_order", 32'(last_win), 32'(i % N));
      if (prev >= 0) check("rr_spacing", 32'(last_gnt_cycle - prev), 32'd2);
      prev = last_gnt_cycle;
    end
`else
    // ---- fixed priority with req=1010 held ----
    lanes = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 4'b1010, 4'b0000, lanes, "fixed");
      check("fixed_winner", 32'(last_win), 32'd1);
    end
`endif
    req = '0;
    op(1'b0, 4'b0000, 4'b0000, '0, "drain");

    // ---- single request ----
    lanes = '0;
    lanes[2*W +: W] = 8'h3C;
    op(1'b0, 4'b0100, 4'b0000, lanes, "single");
    check("single_q_const", 32'(q), 32'h3C);
    check("single_owner_const", 32'(owner), 32'd2);

    // ---- clear priority ----
    lanes = '0;
    lanes[1*W +: W] = 8'hFF;
    op(1'b0, 4'b0010, 4'b0000, lanes, "preload");
    check("preload_q_const", 32'(q), 32'hFF);
    lanes = '0;
    lanes[0 +: W] = 8'h5A;
    op(1'b1, 4'b0001, 4'b0000, lanes, "clrpri");
    check("clrpri_q_zero", 32'(q), 32'd0);
    op(1'b0, 4'b0000, 4'b0000, lanes, "clrpri_grant");
    check("clrpri_winner", 32'(last_win), 32'd0);
    check("clrpri_q_const", 32'(q), 32'h5A);

    // ---- busy deferral: req3 rises during requester 0's GRANT ----
    lanes = {8'hC3, 8'h00, 8'h00, 8'h77};
    op(1'b0, 4'b0001, 4'b1000, lanes, "defer_first");
    op(1'b0, 4'b0000, 4'b0000, lanes, "defer_second");
    check("defer_winner", 32'(last_win), 32'd3);
    check("defer_q_const", 32'(q), 32'hC3);

    // ---- randomized operations ----
    for (int n = 0; n < 80; n++) begin
      logic c;
      logic [N-1:0] nb, lb;
      lanes = {$urandom, $urandom};
      c  = ($urandom_range(0, 5) == 0);
      nb = N'($urandom);
      lb = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      op(c, nb, lb, lanes, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Arbitrates write access to one shared WIDTH-bit D-flip-flop storage register among N_REQ requesters.
- Also sequences a synchronous clear of that register.
- Sits between the requesting datapath blocks and the shared storage.
- Grants one requester at a time via a req/gnt handshake, so the register is never written by two sources in the same cycle.

## Interface
- N_REQ, default 4: number of requesters; legal range 2–8.
- WIDTH, default 8: width of the shared register and of each write-data lane.
- IDXW, default 2: owner index width; must equal clog2(N_REQ).
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clr  input  1  request to clear the shared register to 0.
- req  input  N_REQ  per-requester write request; level, held until granted.
- wdata  input  N_REQ*WIDTH  write data; lane i is bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant; all zero outside GRANT.
- q  output  WIDTH  shared register contents.
- busy  output  1  high whenever state is not IDLE.
- owner  output  IDXW  index of the last requester whose data was written.

## Operation
- FSM states are IDLE, GRANT and CLEAR. Reset value is IDLE.
- IDLE, clr=1: go to CLEAR. clr has priority over any req.
- IDLE, clr=0 and req≠0: latch the winner index, then go to GRANT.
- IDLE, otherwise: stay in IDLE.
- GRANT lasts exactly one cycle:
  - gnt[winner]=1.
  - At the closing edge: q <= lane[winner], owner <= winner, pointer <= (winner+1) mod N_REQ.
  - Then go to IDLE.
- CLEAR lasts exactly one cycle. At the closing edge q <= 0, then go to IDLE. Pointer and owner are unchanged.
- Round-robin arbitration:
  - Search req starting at the pointer, ascending, wrapping from N_REQ-1 to 0. First set bit wins.
  - Pointer reset value is 0.
- Requester rules:
  - Hold req and the wdata lane stable until gnt is seen.
  - Deassert req at the edge that ends the gnt cycle.
  - A req still high in the following IDLE cycle is a new request.
- Requests and clr that arrive while busy=1 are not lost; they are sampled at the next IDLE edge.
- Reset values: q=0, gnt=0, busy=0, owner=0, pointer=0, state=IDLE.
- Reset asserted mid-GRANT or mid-CLEAR:
  - Aborts the operation at once; no write occurs.
  - Outputs take their reset values asynchronously.

## Timing
- Latency from req sampled high in IDLE to gnt high: 1 cycle.
- New q is visible the cycle after GRANT, i.e. 2 edges after the sampling edge.
- Clear latency: clr sampled in IDLE, then CLEAR, then q=0 at the following edge.
- Each operation takes 2 cycles (IDLE then GRANT or CLEAR), so peak throughput is one write per 2 cycles.
- Fairness: with all N_REQ requests held continuously, each requester is granted once every 2*N_REQ cycles.
- gnt and busy are registered state decodes; they have no combinational path from req or clr.

## Configuration
- Macro ARB_FIXED_PRIORITY_EN selects the arbitration scheme.
- Defined: fixed priority. The lowest set req index always wins, and the pointer logic is removed.
- Undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package shared_reg_arb_pkg holds:
  - the state enum (IDLE, GRANT, CLEAR);
  - the default N_REQ and WIDTH constants;
  - a function computing IDXW from N_REQ.
- One sub-module, rr_pick:
  - inputs: req vector and pointer; outputs: winner index and valid flag.
  - Combinational; collapses to lowest-index priority when ARB_FIXED_PRIORITY_EN is defined.
- The register q is written only in this block.

## Test plan
- Reset: assert reset mid-GRANT with lane0=8'hA5.
  - Required: q stays 0, gnt=0, busy=0 immediately; no write after release.
- Single request: req=4'b0100, lane2=8'h3C.
  - Required: gnt=4'b0100 one cycle later, q=8'h3C and owner=2 the cycle after.
- Round-robin: req=4'b1111 held continuously, data 8'h10–8'h13.
  - Required grant order 0,1,2,3,0; each gnt pulse 2 cycles apart.
- Clear priority: clr=1 and req=4'b0001 in the same IDLE cycle, with q=8'hFF.
  - Required: CLEAR first, so q=0; then GRANT to requester 0; pointer unchanged by the clear.
- Busy deferral: req3 rises during another requester's GRANT.
  - Required: req3 is sampled at the next IDLE edge and granted; no request is dropped.
- Fixed-priority build (ARB_FIXED_PRIORITY_EN defined): req=4'b1010 held continuously.
  - Required: requester 1 is granted every time and requester 3 is never granted.
